// File: rtl/sdram_line_requester.sv
// Single-line write-back buffer that turns 32-bit CPU word accesses into
// whole 8 x 16-bit line transactions towards the SDRAM wrapper user port.
module sdram_line_requester #(
  parameter int CPU_ADDR_W = 25,
  parameter int MEM_ADDR_W = 24,
  parameter int TAG_W      = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  input  logic                  cpu_wr,
  input  logic [CPU_ADDR_W-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_be,
  output logic                  cpu_ready,
  output logic [31:0]           cpu_rdata,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic                  mem_valid,
  output logic [127:0]          mem_line_out,
  input  logic [127:0]          mem_line_in,
  input  logic                  mem_done,
  input  logic                  mem_init_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic                    buf_valid_q, buf_valid_d;
  logic                    buf_dirty_q, buf_dirty_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [TAG_W-1:0]        buf_tag_q, buf_tag_d;
  logic [127:0]            line_q, line_d;
  logic                    mem_valid_q, mem_valid_d;
  logic                    mem_wr_q, mem_wr_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [127:0]            mem_line_out_q, mem_line_out_d;
  logic                    flush_done_q, flush_done_d;

  logic [TAG_W-1:0]        req_tag;
  logic [1:0]              req_word;
  logic                    hit;
  logic                    done_seen;
  logic                    start_wb;
  logic                    start_fill;
  logic                    unused_addr_lsb;

  assign req_tag         = cpu_addr[CPU_ADDR_W-1:4];
  assign req_word        = cpu_addr[3:2];
  assign unused_addr_lsb = ^cpu_addr[1:0];
  assign hit             = buf_valid_q && (req_tag == buf_tag_q);
  // A stray mem_done while no request is outstanding must not be acted on.
  assign done_seen       = mem_done && mem_valid_q;

  always_comb begin
    // NOTE: every _d starts from its _q value, so no path through this block can infer a latch.
    state_d         = state_q;
    buf_valid_d     = buf_valid_q;
    buf_dirty_d     = buf_dirty_q;
    flush_pending_d = flush_pending_q;
    buf_tag_d       = buf_tag_q;
    line_d          = line_q;
    mem_valid_d     = mem_valid_q;
    mem_wr_d        = mem_wr_q;
    mem_rd_d        = mem_rd_q;
    mem_addr_d      = mem_addr_q;
    mem_line_out_d  = mem_line_out_q;
    flush_done_d    = 1'b0;
    start_wb        = 1'b0;
    start_fill      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_init_done) begin
          if (flush) begin
            if (buf_valid_q && buf_dirty_q) begin
              state_d         = S_WB;
              flush_pending_d = 1'b1;
              start_wb        = 1'b1;
            end else begin
              buf_valid_d  = 1'b0;
              flush_done_d = 1'b1;
            end
          end else if (cpu_valid) begin
            if (hit) begin
              state_d = S_RESP;
            end else if (buf_valid_q && buf_dirty_q) begin
              state_d  = S_WB;
              start_wb = 1'b1;
            end else begin
              state_d    = S_FILL;
              start_fill = 1'b1;
            end
          end
        end
      end

      S_WB: begin
        if (done_seen) begin
          mem_valid_d = 1'b0;
          mem_wr_d    = 1'b0;
          buf_dirty_d = 1'b0;
          if (flush_pending_q) begin
            buf_valid_d     = 1'b0;
            flush_pending_d = 1'b0;
            flush_done_d    = 1'b1;
            state_d         = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        // After a write-back, valid spends one cycle low before the read is issued.
        if (!mem_valid_q) begin
          start_fill = 1'b1;
        end else if (mem_done) begin
          line_d      = mem_line_in;
          buf_tag_d   = mem_addr_q[MEM_ADDR_W-1:3];
          buf_valid_d = 1'b1;
          buf_dirty_d = 1'b0;
          mem_valid_d = 1'b0;
          mem_rd_d    = 1'b0;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (cpu_wr) begin
          for (int b = 0; b < 4; b++) begin
            if (cpu_be[b]) begin
              line_d[32*int'(req_word) + 8*b +: 8] = cpu_wdata[8*b +: 8];
            end
          end
          buf_dirty_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (start_wb) begin
      mem_valid_d    = 1'b1;
      mem_wr_d       = 1'b1;
      mem_rd_d       = 1'b0;
      mem_addr_d     = {buf_tag_q, 3'b000};
      mem_line_out_d = line_q;
    end
    if (start_fill) begin
      mem_valid_d = 1'b1;
      mem_wr_d    = 1'b0;
      mem_rd_d    = 1'b1;
      mem_addr_d  = {req_tag, 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    if (rst) begin
      state_q         <= S_IDLE;
      buf_valid_q     <= 1'b0;
      buf_dirty_q     <= 1'b0;
      flush_pending_q <= 1'b0;
      buf_tag_q       <= '0;
      // NOTE: the line storage is a plain register and is cleared so its reset contents are defined.
      line_q          <= '0;
      mem_valid_q     <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_line_out_q  <= '0;
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      buf_valid_q     <= buf_valid_d;
      buf_dirty_q     <= buf_dirty_d;
      flush_pending_q <= flush_pending_d;
      buf_tag_q       <= buf_tag_d;
      line_q          <= line_d;
      mem_valid_q     <= mem_valid_d;
      mem_wr_q        <= mem_wr_d;
      mem_rd_q        <= mem_rd_d;
      mem_addr_q      <= mem_addr_d;
      mem_line_out_q  <= mem_line_out_d;
      flush_done_q    <= flush_done_d;
    end
  end

  always_comb begin
    cpu_rdata = '0;
    if ((state_q == S_RESP) && !cpu_wr) begin
      cpu_rdata = line_q[32*int'(req_word) +: 32];
    end
  end

  assign cpu_ready    = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign flush_done   = flush_done_q;
  assign mem_valid    = mem_valid_q;
  assign mem_wr       = mem_wr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign mem_line_out = mem_line_out_q;

endmodule

// File: tb/tb_sdram_line_requester.sv
// Scoreboard bench: a reference word memory and buffer model predict CPU data
// and SDRAM traffic; a behavioural SDRAM port answers line requests.
module tb_sdram_line_requester;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_valid = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [24:0]   cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [3:0]    cpu_be = '0;
  logic          cpu_ready;
  logic [31:0]   cpu_rdata;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          busy;
  logic [23:0]   mem_addr;
  logic          mem_wr;
  logic          mem_rd;
  logic          mem_valid;
  logic [127:0]  mem_line_out;
  logic [127:0]  mem_line_in = '0;
  logic          mem_done = 1'b0;
  logic          mem_init_done = 1'b0;

  sdram_line_requester dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_valid(mem_valid),
    .mem_line_out(mem_line_out), .mem_line_in(mem_line_in), .mem_done(mem_done),
    .mem_init_done(mem_init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [23:0]  addr;
    logic [127:0] line;
  } mem_exp_t;

  mem_exp_t      mem_q[$];
  logic [31:0]   cpu_q[$];
  logic [31:0]   gold [int];
  logic [127:0]  sdram [int];

  int            n_checks = 0;
  int            n_pass = 0;
  int            n_tx = 0;
  logic [23:0]   last_wb_addr = '0;
  logic [23:0]   last_fill_addr = '0;
  bit            stray_req = 1'b0;
  bit            rsp_busy = 1'b0;
  bit            prev_valid = 1'b0;

  bit            m_valid = 1'b0;
  bit            m_dirty = 1'b0;
  logic [20:0]   m_tag = '0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pat(input int w);
    return 32'h5A00_0000 | 32'(w);
  endfunction

  function automatic logic [31:0] gold_word(input int w);
    return gold.exists(w) ? gold[w] : pat(w);
  endfunction

  function automatic logic [127:0] gold_line(input logic [20:0] t);
    int b = int'(t) * 4;
    return {gold_word(b + 3), gold_word(b + 2), gold_word(b + 1), gold_word(b)};
  endfunction

  function automatic logic [127:0] sdram_line(input logic [20:0] t);
    int b = int'(t) * 4;
    if (sdram.exists(int'(t))) return sdram[int'(t)];
    return {pat(b + 3), pat(b + 2), pat(b + 1), pat(b)};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic void push_mem(input logic wr, input logic [23:0] addr, input logic [127:0] line);
    mem_exp_t e;
    e.wr = wr; e.addr = addr; e.line = line;
    mem_q.push_back(e);
  endfunction

  // Behavioural SDRAM port: 2..5 cycle latency, one-cycle mem_done pulse.
  initial begin : responder
    int          cnt;
    logic        cur_wr;
    logic [23:0] cur_addr;
    mem_exp_t    e;
    cnt = 0; cur_wr = 1'b0; cur_addr = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (rst) begin
        rsp_busy = 1'b0;
      end else if (rsp_busy) begin
        cnt--;
        if (cnt == 0) begin
          if (cur_wr) sdram[int'(cur_addr[23:3])] = mem_line_out;
          else        mem_line_in = sdram_line(cur_addr[23:3]);
          mem_done = 1'b1;
          rsp_busy = 1'b0;
        end
      end else if (stray_req && !mem_valid) begin
        mem_line_in = {4{32'hBAD0_BAD0}};
        mem_done    = 1'b1;
        stray_req   = 1'b0;
      end else if (mem_valid && !prev_valid) begin
        n_tx++;
        if (mem_q.size() == 0) begin
          check("mem_unexpected_tx", 1, 0);
        end else begin
          e = mem_q.pop_front();
          check("mem_wr", mem_wr, e.wr);
          check("mem_rd", mem_rd, !e.wr);
          check("mem_addr", mem_addr, e.addr);
          if (e.wr) check("mem_line_out", mem_line_out, e.line);
        end
        if (mem_wr) last_wb_addr = mem_addr;
        else        last_fill_addr = mem_addr;
        cur_wr   = mem_wr;
        cur_addr = mem_addr;
        cnt      = $urandom_range(5, 2);
        rsp_busy = 1'b1;
      end
      prev_valid = mem_valid;
    end
  end

  task automatic cpu_req(input logic wr, input logic [24:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int hold, output int lat, output logic [31:0] rd);
    logic [20:0] tag;
    int          w;
    int          stall;
    logic [31:0] exp;
    logic [31:0] popped;
    tag = addr[24:4];
    w   = int'(addr[24:2]);
    if (!(m_valid && m_tag == tag)) begin
      if (m_valid && m_dirty) push_mem(1'b1, {m_tag, 3'b000}, gold_line(m_tag));
      push_mem(1'b0, {tag, 3'b000}, '0);
      m_valid = 1'b1; m_tag = tag; m_dirty = 1'b0;
    end
    if (wr) begin
      exp = '0;
      gold[w] = merge(gold_word(w), wd, be);
      m_dirty = 1'b1;
    end else begin
      exp = gold_word(w);
    end
    cpu_q.push_back(exp);
    cpu_valid = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
    if (hold > 0) begin
      stall = 0;
      repeat (hold) begin
        @(negedge clk);
        if (mem_valid || cpu_ready) stall++;
      end
      check("init_gate_activity", stall, 0);
      mem_init_done = 1'b1;
    end
    lat = 0;
    rd  = '0;
    forever begin
      @(negedge clk);
      lat++;
      if (cpu_ready || lat >= 400) break;
    end
    popped = cpu_q.pop_front();
    if (!cpu_ready) begin
      check("cpu_ready_timeout", 0, 1);
    end else begin
      rd = cpu_rdata;
      check("cpu_rdata", rd, popped);
    end
    cpu_valid = 1'b0;
    @(negedge clk);
    check("cpu_ready_single", cpu_ready, 0);
  endtask

  task automatic do_flush(output int lat, output int ntx);
    int tx0;
    int extra;
    tx0 = n_tx;
    extra = 0;
    if (m_valid && m_dirty) push_mem(1'b1, {m_tag, 3'b000}, gold_line(m_tag));
    m_valid = 1'b0; m_dirty = 1'b0;
    flush = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (flush_done || lat >= 400) break;
    end
    check("flush_done_seen", flush_done, 1);
    flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (flush_done) extra++;
    end
    check("flush_done_single", extra, 0);
    ntx = n_tx - tx0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int          lat;
    int          ntx;
    int          tx0;
    int          cnt;
    logic [31:0] rd;
    logic [20:0] rt;

    // Cold-read line at 0x104: line words 2,3 hold 0xBEEF, 0xDEAD.
    gold[32'h41]  = 32'hDEAD_BEEF;
    sdram[32'h10] = {pat(32'h43), pat(32'h42), 32'hDEAD_BEEF, pat(32'h40)};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {cpu_ready, cpu_rdata, flush_done, busy, mem_addr, mem_wr, mem_rd, mem_valid, mem_line_out}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Request held for 50 cycles before init completes, then a normal fill.
    tx0 = n_tx;
    cpu_req(1'b0, 25'h0003000, '0, '0, 50, lat, rd);
    check("init_fill_data", rd, 32'h5A00_0C00);
    check("init_fill_tx", n_tx - tx0, 1);

    tx0 = n_tx;
    cpu_req(1'b0, 25'h0000104, '0, '0, 0, lat, rd);
    check("cold_read_data", rd, 32'hDEAD_BEEF);
    check("cold_read_addr", last_fill_addr, 24'h000080);
    check("cold_read_tx", n_tx - tx0, 1);

    // Write hit: valid seen at the first edge, ready sampled at the next.
    tx0 = n_tx;
    cpu_req(1'b1, 25'h0000108, 32'h1122_3344, 4'b0101, 0, lat, rd);
    check("write_hit_latency", lat, 1);
    check("write_hit_tx", n_tx - tx0, 0);
    cpu_req(1'b0, 25'h0000108, '0, '0, 0, lat, rd);
    check("write_merge_data", rd, 32'h5A22_0044);

    tx0 = n_tx;
    cpu_req(1'b0, 25'h0000200, '0, '0, 0, lat, rd);
    check("dirty_miss_tx", n_tx - tx0, 2);
    check("dirty_miss_wb_addr", last_wb_addr, 24'h000080);
    check("dirty_miss_fill_addr", last_fill_addr, 24'h000100);

    cpu_req(1'b1, 25'h0000204, 32'h0102_0304, 4'hF, 0, lat, rd);
    do_flush(lat, ntx);
    check("dirty_flush_tx", ntx, 1);
    check("dirty_flush_wb_addr", last_wb_addr, 24'h000100);
    tx0 = n_tx;
    cpu_req(1'b0, 25'h0000204, '0, '0, 0, lat, rd);
    check("post_flush_fill_tx", n_tx - tx0, 1);
    check("post_flush_data", rd, 32'h0102_0304);
    do_flush(lat, ntx);
    check("clean_flush_latency", lat, 1);
    check("clean_flush_tx", ntx, 0);

    // Zero byte enables: data unchanged but the line still becomes dirty.
    cpu_req(1'b0, 25'h0000300, '0, '0, 0, lat, rd);
    cpu_req(1'b1, 25'h0000300, 32'hFFFF_FFFF, 4'b0000, 0, lat, rd);
    do_flush(lat, ntx);
    check("be0_flush_tx", ntx, 1);
    cpu_req(1'b0, 25'h0000300, '0, '0, 0, lat, rd);
    check("be0_data", rd, 32'h5A00_00C0);

    // A stray mem_done while idle must leave the buffer untouched.
    cpu_req(1'b0, 25'h0000104, '0, '0, 0, lat, rd);
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_done_idle", {busy, cpu_ready, mem_valid}, 3'b000);
    cpu_req(1'b0, 25'h0000104, '0, '0, 0, lat, rd);
    check("stray_done_hit_latency", lat, 1);
    check("stray_done_data", rd, 32'hDEAD_BEEF);

    cpu_req(1'b0, 25'h1FFFFFC, '0, '0, 0, lat, rd);
    check("top_line_fill_addr", last_fill_addr, 24'hFFFFF8);

    // Reset while a write-back is outstanding; the dirty word is lost.
    cpu_req(1'b1, 25'h1FFFFFC, 32'hCAFE_F00D, 4'hF, 0, lat, rd);
    push_mem(1'b1, 24'hFFFFF8, gold_line(21'h1FFFFF));
    cpu_valid = 1'b1; cpu_wr = 1'b0; cpu_addr = 25'h0000500;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt++;
      if ((mem_valid && mem_wr) || cnt >= 100) break;
    end
    @(negedge clk);
    check("wb_in_progress", {mem_valid, mem_wr}, 2'b11);
    rst = 1'b1;
    cpu_valid = 1'b0;
    @(negedge clk);
    check("mid_wb_reset_outputs",
          {cpu_ready, cpu_rdata, flush_done, busy, mem_addr, mem_wr, mem_rd, mem_valid, mem_line_out}, '0);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_dirty = 1'b0;
    rt = 21'h1FFFFF;
    for (int k = 0; k < 4; k++) gold[int'(rt) * 4 + k] = sdram_line(rt)[32*k +: 32];
    tx0 = n_tx;
    cpu_req(1'b0, 25'h1FFFFFC, '0, '0, 0, lat, rd);
    check("post_reset_fill_tx", n_tx - tx0, 1);
    check("post_reset_data", rd, 32'h5A7F_FFFF);

    // Mixed traffic over three competing lines.
    for (int i = 0; i < 40; i++) begin
      logic [20:0] t;
      logic [1:0]  wi;
      case ($urandom_range(2, 0))
        0:       t = 21'h000010;
        1:       t = 21'h000020;
        default: t = 21'h1FFFFF;
      endcase
      wi = 2'($urandom_range(3, 0));
      if ($urandom_range(9, 0) == 0) do_flush(lat, ntx);
      else cpu_req(1'($urandom_range(1, 0)), {t, wi, 2'b00}, $urandom, 4'($urandom_range(15, 0)), 0, lat, rd);
    end

    repeat (10) @(negedge clk);
    check("mem_queue_drained", mem_q.size(), 0);
    check("cpu_queue_drained", cpu_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_line_requester.md
Name: sdram_line_requester

Overview:
- Initiator side of the SDRAM line-transaction interface (addr/wr/rd/valid -> done, 8 x 16-bit line).
- Turns 32-bit CPU word reads/writes with byte enables into whole-line SDRAM transactions through a single-line write-back buffer: one tag, valid bit, dirty bit and 128-bit line.
- Sits between the core memory stage and the SDRAM wrapper, in the same clock domain as the wrapper's user port.

Parameters:
- CPU_ADDR_W, 25, CPU byte-address width (32 MB space).
- MEM_ADDR_W, 24, SDRAM 16-bit-word address width; must equal CPU_ADDR_W-1.
- TAG_W, 21, line tag width = CPU_ADDR_W-4 (16-byte lines).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cpu_valid  in  1  request present; held with all request fields until cpu_ready
- cpu_wr  in  1  1=write, 0=read
- cpu_addr  in  CPU_ADDR_W  byte address; bits[1:0] ignored
- cpu_wdata  in  32  write data
- cpu_be  in  4  byte enables for writes
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  read data; valid while cpu_ready=1
- flush  in  1  level request: write back if dirty, then invalidate
- flush_done  out  1  one-cycle pulse when flush is complete
- busy  out  1  state != IDLE
- mem_addr  out  MEM_ADDR_W  line base word address, {tag,3'b000}
- mem_wr  out  1  write-line request
- mem_rd  out  1  read-line request
- mem_valid  out  1  transaction request
- mem_line_out  out  128  line to write; word k = bits[16k+15:16k]
- mem_line_in  in  128  line read back; sampled on mem_done
- mem_done  in  1  one-cycle transaction-complete pulse
- mem_init_done  in  1  SDRAM initialised; no request is accepted before it is 1

Behaviour:
- Reset: state=IDLE; buf_valid=0, buf_dirty=0; tag=0, line=0; all outputs 0.
- Address decode:
  - tag = cpu_addr[24:4]
  - 32-bit word index = cpu_addr[3:2]
  - CPU word k = {line word 2k+1, line word 2k} (little-endian).
- hit = buf_valid && tag==buf_tag.
- IDLE (priority order):
  - !mem_init_done: stay.
  - flush: if buf_valid && buf_dirty -> WB, with flush_pending=1; else clear buf_valid, pulse flush_done next cycle, stay IDLE.
  - cpu_valid && hit -> RESP.
  - cpu_valid && miss && buf_valid && buf_dirty -> WB.
  - cpu_valid && miss otherwise -> FILL.
  - flush has priority over cpu_valid when both are present.
- WB:
  - Outputs registered, set on entry: mem_valid=1, mem_wr=1, mem_rd=0, mem_addr={buf_tag,000}, mem_line_out=buffered line.
  - All held stable until mem_done.
  - On mem_done: mem_valid=0 and buf_dirty=0 at the same edge.
  - Next: if flush_pending, clear buf_valid and flush_pending, pulse flush_done -> IDLE; else -> FILL.
- FILL:
  - mem_valid=1, mem_rd=1, mem_wr=0, mem_addr={cpu_addr tag,000}, held until mem_done.
  - On mem_done: capture mem_line_in; buf_tag=new tag; buf_valid=1; buf_dirty=0; mem_valid=0 -> RESP.
- RESP (one cycle):
  - cpu_ready=1.
  - Read: cpu_rdata = selected word.
  - Write: merge cpu_wdata into the selected word per cpu_be, set buf_dirty=1, cpu_rdata=0.
  - Next: IDLE.
  - The write merge is visible to any following request.
- Latency:
  - Hit: cpu_ready 2 cycles after cpu_valid is first seen in IDLE (IDLE -> RESP, pulse in RESP).
  - Miss: the hit latency plus the duration of each mem transaction.
- Handshake:
  - mem_valid deasserts on the same edge mem_done is sampled, so the wrapper's next IDLE cycle sees valid=0; no back-to-back duplicate transaction.
  - mem_wr and mem_rd are never 1 together.
  - mem_valid never rises in the cycle after a mem_done without a state transition.
- Boundaries:
  - cpu_be=0 write: completes with no data change but still sets dirty.
  - mem_done while mem_valid=0: ignored.
  - cpu_valid dropped mid-miss: protocol violation; the transaction completes anyway.
  - Addresses at the top line (tag all ones) map to mem_addr=24'hFFFFF8 with no wrap.
- Reset mid-transaction: all state discarded and mem_valid dropped in the same cycle. The system resets the SDRAM wrapper together with this block; dirty data is lost.

Test Plan:
- Cold read, cpu_addr=0x000104 -> FILL with mem_addr=0x000080, mem_rd=1; return line words w2=0xBEEF, w3=0xDEAD -> cpu_rdata=0xDEADBEEF, cpu_ready one pulse, no mem_wr.
- Write hit addr 0x000108, wdata=0x11223344, be=4'b0101 -> no mem transaction; word 2 becomes {old[31:24],0x22,old[15:8],0x44}; ready 2 cycles after valid; dirty=1.
- Read addr 0x000200 while dirty -> WB at mem_addr=0x000080 carrying the merged line, then FILL at 0x000100; exactly one mem_valid pulse train per transaction.
- flush with dirty buffer -> one write at the current tag, flush_done single pulse, buffer invalid, next same-address read causes FILL; flush on clean buffer -> flush_done next cycle, zero mem traffic.
- mem_init_done=0 with cpu_valid=1 for 50 cycles -> no mem_valid and no cpu_ready; after init, normal FILL.
- rst asserted during WB with mem_valid=1 -> next cycle all outputs 0, state IDLE, buf_valid=0; a following read at the same address performs a FILL.
